// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_pkg
// Description : Shared constants, header field positions and loader state
//               encoding for the fabric configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

   localparam int CFG_WORD_W  = 32;

   // Header word layout: tile address in the upper half, word count below.
   localparam int TILE_ID_MSB = 31;
   localparam int TILE_ID_LSB = 16;
   localparam int COUNT_MSB   = 15;
   localparam int COUNT_LSB   = 0;

   typedef enum logic [1:0] {
      ST_HEADER  = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2,
      ST_CHECK   = 2'd3
   } loader_state_t;

   function automatic logic [15:0] hdr_tile_id(input logic [CFG_WORD_W-1:0] w);
      return w[TILE_ID_MSB:TILE_ID_LSB];
   endfunction

   function automatic logic [15:0] hdr_count(input logic [CFG_WORD_W-1:0] w);
      return w[COUNT_MSB:COUNT_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_byte_packer
// Description : Packs a little-endian byte stream into 32-bit words. The
//               completed word is presented combinationally on the edge that
//               accepts the 4th byte, so the consumer can register it there.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_byte_packer
   import config_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            i_byte,
   input  logic                  i_accept,
   output logic [CFG_WORD_W-1:0] o_word,
   output logic                  o_word_valid,
   output logic                  o_partial
);

   logic [1:0]  r_cnt;
   logic [23:0] r_buf;

   // Byte counter and lower three byte lanes; the 4th byte bypasses storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= 2'd0;
         r_buf <= 24'd0;
      end else if (i_accept) begin
         r_cnt <= r_cnt + 2'd1;
         case (r_cnt)
            2'd0:    r_buf[7:0]   <= i_byte;
            2'd1:    r_buf[15:8]  <= i_byte;
            2'd2:    r_buf[23:16] <= i_byte;
            default: ;
         endcase
      end
   end

   assign o_word       = {i_byte, r_buf};
   assign o_word_valid = i_accept & (r_cnt == 2'd3);
   assign o_partial    = (r_cnt != 2'd0);

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_loader
// Description : Fabric configuration front-end. Packs bitstream bytes into
//               words, parses addressed packets (header: tile_id/count) and
//               strobes one word per cycle into the addressed tile.
//               Optional trailer checksum: define CONFIG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module config_loader
   import config_pkg::*;
#(
   parameter int NUM_TILES = 16,
   parameter int WORD_W    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_W-1:0]    config_data,
   output logic [NUM_TILES-1:0] config_en,
   output logic                 busy,
   output logic                 done,
   output logic                 err_bad_tile,
   output logic                 err_checksum
);

`ifdef CONFIG_LOADER_CHECKSUM_EN
   localparam loader_state_t c_state_after_last = ST_CHECK;
`else
   localparam loader_state_t c_state_after_last = ST_HEADER;
`endif

   logic                  r_in_ready;
   loader_state_t         r_state, w_state_nx;
   logic [15:0]           r_tile_id, w_tile_id_nx;
   logic [15:0]           r_remaining, w_remaining_nx;
   logic [WORD_W-1:0]     r_config_data, w_config_data_nx;
   logic [NUM_TILES-1:0]  r_config_en, w_config_en_nx;
   logic                  r_done, w_done_nx;
   logic                  r_err_bad_tile, w_err_bad_tile_nx;

   logic                  w_accept;
   logic [CFG_WORD_W-1:0] w_word;
   logic                  w_word_valid;
   logic                  w_partial;
   logic [15:0]           w_hdr_tile;
   logic [15:0]           w_hdr_count;
   logic [NUM_TILES-1:0]  w_onehot;

`ifdef CONFIG_LOADER_CHECKSUM_EN
   logic [CFG_WORD_W-1:0] r_csum, w_csum_nx;
   logic                  r_err_checksum, w_err_checksum_nx;
`endif

   // Ready rises on the first edge after reset release and then stays high;
   // no byte can be accepted before that edge, which keeps the release clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_in_ready <= 1'b0;
      else        r_in_ready <= 1'b1;
   end

   assign w_accept = in_valid & r_in_ready;

   cfg_byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .i_byte       (in_data),
      .i_accept     (w_accept),
      .o_word       (w_word),
      .o_word_valid (w_word_valid),
      .o_partial    (w_partial)
   );

   assign w_hdr_tile  = hdr_tile_id(w_word);
   assign w_hdr_count = hdr_count(w_word);
   // Only used in PAYLOAD, where tile_id is known to be in range.
   assign w_onehot    = NUM_TILES'(1'b1) << r_tile_id;

   // Packet parser: next state and registered outputs, advanced per word.
   always_comb begin
      w_state_nx        = r_state;
      w_tile_id_nx      = r_tile_id;
      w_remaining_nx    = r_remaining;
      w_config_data_nx  = r_config_data;
      w_config_en_nx    = '0;
      w_done_nx         = 1'b0;
      w_err_bad_tile_nx = r_err_bad_tile;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      w_csum_nx         = r_csum;
      w_err_checksum_nx = r_err_checksum;
`endif
      if (w_word_valid) begin
         case (r_state)
            ST_HEADER: begin
               w_tile_id_nx   = w_hdr_tile;
               w_remaining_nx = w_hdr_count;
`ifdef CONFIG_LOADER_CHECKSUM_EN
               w_csum_nx      = w_word;
`endif
               if (w_hdr_count == 16'd0) begin
                  w_state_nx = ST_HEADER;
               end else if (32'(w_hdr_tile) >= 32'(NUM_TILES)) begin
                  w_err_bad_tile_nx = 1'b1;
                  w_state_nx        = ST_DROP;
               end else begin
                  w_state_nx = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD, ST_DROP: begin
               if (r_state == ST_PAYLOAD) begin
                  w_config_data_nx = w_word;
                  w_config_en_nx   = w_onehot;
               end
               w_remaining_nx = r_remaining - 16'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
               w_csum_nx      = r_csum ^ w_word;
`endif
               if (r_remaining == 16'd1) begin
                  w_done_nx  = 1'b1;
                  w_state_nx = c_state_after_last;
               end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (w_word != r_csum) w_err_checksum_nx = 1'b1;
               w_state_nx = ST_HEADER;
            end
`endif
            default: w_state_nx = ST_HEADER;
         endcase
      end
   end

   // Parser state and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_HEADER;
         r_tile_id      <= 16'd0;
         r_remaining    <= 16'd0;
         r_config_data  <= '0;
         r_config_en    <= '0;
         r_done         <= 1'b0;
         r_err_bad_tile <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_tile_id      <= w_tile_id_nx;
         r_remaining    <= w_remaining_nx;
         r_config_data  <= w_config_data_nx;
         r_config_en    <= w_config_en_nx;
         r_done         <= w_done_nx;
         r_err_bad_tile <= w_err_bad_tile_nx;
      end
   end

`ifdef CONFIG_LOADER_CHECKSUM_EN
   // Running XOR of header and payload words, plus sticky mismatch flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_csum         <= '0;
         r_err_checksum <= 1'b0;
      end else begin
         r_csum         <= w_csum_nx;
         r_err_checksum <= w_err_checksum_nx;
      end
   end
   assign err_checksum = r_err_checksum;
`else
   assign err_checksum = 1'b0;
`endif

   assign in_ready     = r_in_ready;
   assign config_data  = r_config_data;
   assign config_en    = r_config_en;
   assign done         = r_done;
   assign err_bad_tile = r_err_bad_tile;
   assign busy         = (r_state != ST_HEADER) | w_partial;

endmodule
`default_nettype wire

// File: doc/config_loader.md
Name: config_loader

Overview:
- Front-end of the fabric configuration path; sits directly upstream of every switch box's configuration register.
- Accepts a byte stream from the host/bitstream port and packs it into 32-bit words.
- Parses addressed configuration packets and drives the shared `config_data` bus plus a one-hot per-tile `config_en` strobe.
- The strobe commits one word into the selected tile's configuration register.

Parameters:
- NUM_TILES, 16, number of tiles (switch boxes) on the configuration bus; legal 1..65535.
- WORD_W, 32, configuration word width; fixed to match the switch box config register.

Ports:
- clk  input  1  fabric clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  bitstream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- config_data  output  WORD_W  configuration word broadcast to all tiles.
- config_en  output  NUM_TILES  one-hot write strobe, bit i = tile i.
- busy  output  1  packet in progress (not in HEADER state, or partial word held).
- done  output  1  one-cycle pulse when the last payload word of a packet is issued (or dropped).
- err_bad_tile  output  1  sticky: header addressed tile_id >= NUM_TILES.
- err_checksum  output  1  sticky: trailer mismatch (see Optional Feature).

Behaviour:
- Reset (reset==0, async assert, sync-to-clk deassert inside the block):
  - All outputs 0, including in_ready.
  - State = HEADER; byte counter = 0; word count = 0.
- in_ready:
  - 1 one cycle after reset deassertion.
  - Then stays 1 permanently; the block never stalls the stream because tile config writes take one cycle.
- Byte transfer occurs on a clk edge with in_valid & in_ready.
- Byte packing:
  - Bytes are little-endian: the first byte goes to bits [7:0], the fourth to [31:24].
  - The 2-bit byte counter wraps 3->0.
  - A word completes on the edge accepting the 4th byte.
- States (evaluated on word completion only): HEADER, PAYLOAD, DROP, CHECK (CHECK only with the macro).
- HEADER:
  - Latch tile_id = word[31:16] and remaining = word[15:0].
  - remaining==0: stay in HEADER, no strobe, no done.
  - tile_id >= NUM_TILES: set err_bad_tile, go to DROP.
  - Otherwise: go to PAYLOAD.
- PAYLOAD, each completed word:
  - config_data <= word; config_en <= one-hot(tile_id) for exactly one cycle.
  - remaining decrements.
  - On the last word (remaining==1): done pulses in the same cycle as the strobe; next state is HEADER (or CHECK with the macro).
- DROP:
  - Consumes remaining words with no strobe.
  - done pulses on the last word; then HEADER.
- Latency: config_en/config_data are registered and valid the cycle after the 4th byte's acceptance edge.
- config_data holds its last value between strobes; config_en is 0 otherwise.
- Back-to-back packets: a header word may complete on the edge right after the last payload word; no bubble is required.
- Error flags: stay set until reset; they do not halt parsing.
- Reset mid-packet: the partial word and remaining count are discarded; no strobe is issued for the discarded data.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- Defined:
  - Each packet with remaining>0 is followed by one trailer word.
  - Expected trailer = XOR of the header word and all payload words.
  - After the last payload word, state = CHECK. The trailer word returns to HEADER and sets err_checksum on mismatch.
  - Written words are not rolled back.
  - Dropped packets are also checked.
- Undefined: no CHECK state, no trailer; err_checksum tied 0.

Decomposition:
- Package config_pkg:
  - CFG_WORD_W=32.
  - Header field constants: TILE_ID_MSB=31, TILE_ID_LSB=16, COUNT_MSB=15, COUNT_LSB=0.
  - Loader state enum.
- Sub-module cfg_byte_packer:
  - Byte counter and 32-bit shift/assemble register.
  - Outputs word + word_valid pulse.
  - Instantiated once; the FSM, decoder and checksum stay in config_loader.

Test Plan:
- Reset then idle:
  - Hold reset=0 for 3 cycles with in_valid toggling -> all outputs 0.
  - in_ready rises 1 cycle after release; no config_en.
- Single write:
  - Bytes 02 00 03 00 | 01 00 00 00 | EF BE AD DE (header tile 3, count 2; payload 0x00000001, 0xDEADBEEF).
  - Expect config_en=0x0008 with 0x00000001.
  - Then config_en=0x0008 with 0xDEADBEEF, with done on the second strobe.
- Bad tile:
  - Header tile_id=16 (NUM_TILES=16), count=2, plus 8 payload bytes.
  - Expect err_bad_tile=1, no config_en, done on the last dropped word.
  - A following valid packet writes normally.
- Zero-count and back-to-back:
  - Header count=0 -> no strobe, no done.
  - Immediately after, tile 0 count 1 then tile 15 count 1 with continuous in_valid -> strobes 0x0001 then 0x8000, each a cycle after its 4th byte.
- Gapped input:
  - Insert random in_valid=0 gaps inside words -> identical config_data/config_en sequence to the gapless run.
- Reset mid-word and checksum:
  - Assert reset after 2 payload bytes -> no strobe; parsing restarts at HEADER.
  - With CONFIG_LOADER_CHECKSUM_EN: correct trailer keeps err_checksum=0; trailer XOR 1 sets err_checksum=1.
